// File: rtl/div_if.sv
// div_if: operand/handshake bus between the execute stage and the divider
interface div_if #(parameter int DATA_W = 32);
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
  modport slave (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider returning {remainder, quotient}
module div_ctrl #(parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t              state, state_n;
  logic [2*DATA_W:0]   dividend, dividend_n;
  logic [DATA_W-1:0]   divisor, divisor_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                neg_a, neg_b, sdiv, neg_a_n, neg_b_n, sdiv_n;
  logic [2*DATA_W-1:0] result, result_n;
  logic                ready, ready_n;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   abs_a, abs_b, quo, rem, quo_c, rem_c;
  assign abs_a = (d.signed_div_i && d.opdata1_i[DATA_W-1]) ? -d.opdata1_i : d.opdata1_i;
  assign abs_b = (d.signed_div_i && d.opdata2_i[DATA_W-1]) ? -d.opdata2_i : d.opdata2_i;
  assign diff  = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  assign quo   = dividend[DATA_W-1:0];
  assign rem   = dividend[2*DATA_W:DATA_W+1];
  // remainder takes the dividend's sign, quotient is negative when signs differ
  assign quo_c = (sdiv && (neg_a ^ neg_b)) ? -quo : quo;
  assign rem_c = (sdiv && neg_a) ? -rem : rem;
  assign d.result_o = result;
  assign d.ready_o  = ready;
  always_comb begin
    state_n    = state;
    dividend_n = dividend;
    divisor_n  = divisor;
    cnt_n      = cnt;
    neg_a_n    = neg_a;
    neg_b_n    = neg_b;
    sdiv_n     = sdiv;
    result_n   = result;
    ready_n    = ready;
    case (state)
      FREE: if (d.start_i && !d.annul_i) begin
        neg_a_n = d.opdata1_i[DATA_W-1];
        neg_b_n = d.opdata2_i[DATA_W-1];
        sdiv_n  = d.signed_div_i;
        if (d.opdata2_i == '0) state_n = BYZERO;
        else begin
          state_n    = ON;
          cnt_n      = '0;
          dividend_n = {{DATA_W{1'b0}}, abs_a, 1'b0};
          divisor_n  = abs_b;
        end
      end
      BYZERO: begin
        dividend_n = '0;
        state_n    = END;
      end
      ON: if (d.annul_i) begin
        state_n = FREE;
        cnt_n   = '0;
      end else if (cnt != CW'(DATA_W)) begin
        dividend_n = diff[DATA_W] ? {dividend[2*DATA_W-1:0], 1'b0}
                                  : {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
        cnt_n      = cnt + 1'b1;
      end else begin
        dividend_n = {rem_c, dividend[DATA_W], quo_c};
        state_n    = END;
        cnt_n      = '0;
      end
      END: begin
        ready_n  = d.start_i;
        result_n = d.start_i ? {rem, quo} : '0;
        state_n  = d.start_i ? END : FREE;
      end
      default: state_n = FREE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      dividend <= '0;
      divisor  <= '0;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      sdiv     <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_n;
      dividend <= dividend_n;
      divisor  <= divisor_n;
      cnt      <= cnt_n;
      neg_a    <= neg_a_n;
      neg_b    <= neg_b_n;
      sdiv     <= sdiv_n;
      result   <= result_n;
      ready    <= ready_n;
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random checks of div_ctrl against an arithmetic reference
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  div_if #(.DATA_W(32)) bus();
  div_ctrl #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .d(bus));
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint na, nb;
    if (b == 32'd0) return 64'd0;
    na = s ? longint'($signed(a)) : longint'({32'd0, a});
    nb = s ? longint'($signed(b)) : longint'({32'd0, b});
    return {32'(na % nb), 32'(na / nb)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
  endtask
  // called on the negedge before E0; checks ready stays low until E<lat>
  task automatic expect_done(input string tag, input int lat, input logic [63:0] exp, input bit scr);
    int early = 0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) early++;
      if (scr) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, " early"}, 64'(early), 64'd0);
    @(negedge clk);
    chk({tag, " ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " result"}, bus.result_o, exp);
  endtask
  task automatic finish_op(input string tag);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk({tag, " clr ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, " clr result"}, bus.result_o, 64'd0);
  endtask
  initial begin
    logic [31:0] a, b;
    logic        s;
    int          lat;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(bus.ready_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    rst = 1'b1;
    start_op(32'd100, 32'd7, 1'b0);
    expect_done("u100/7", 34, {32'd2, 32'd14}, 1'b0);
    @(negedge clk);
    chk("u100/7 hold ready", 64'(bus.ready_o), 64'd1);
    chk("u100/7 hold result", bus.result_o, {32'd2, 32'd14});
    finish_op("u100/7");
    start_op(32'hFFFFFFF9, 32'd2, 1'b1);
    expect_done("s-7/2", 34, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    finish_op("s-7/2");
    start_op(32'd7, 32'hFFFFFFFE, 1'b1);
    expect_done("s7/-2", 34, {32'h00000001, 32'hFFFFFFFD}, 1'b0);
    finish_op("s7/-2");
    start_op(32'd5, 32'd0, 1'b1);
    expect_done("s5/0", 2, 64'd0, 1'b0);
    finish_op("s5/0");
    start_op(32'd5, 32'd0, 1'b0);
    expect_done("u5/0", 2, 64'd0, 1'b0);
    finish_op("u5/0");
    // annul at cnt=10, then annul+start together in FREE must not be accepted
    start_op(32'd100, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    chk("annul pre ready", 64'(bus.ready_o), 64'd0);
    bus.annul_i   = 1'b1;
    bus.opdata1_i = 32'hFFFFFFFF;
    bus.opdata2_i = 32'd1;
    @(negedge clk);
    chk("annul ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    expect_done("annul restart", 34, {32'd0, 32'hFFFFFFFF}, 1'b0);
    finish_op("annul restart");
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    expect_done("overflow", 34, {32'd0, 32'h80000000}, 1'b1);
    finish_op("overflow");
    start_op(32'd100, 32'd7, 1'b0);
    repeat (21) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst mid ready", 64'(bus.ready_o), 64'd0);
    chk("rst mid result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start_op(32'd9, 32'd3, 1'b0);
    expect_done("u9/3", 34, {32'd0, 32'd3}, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst end ready", 64'(bus.ready_o), 64'd0);
    chk("rst end result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      s = 1'($urandom_range(0, 1));
      lat = (b == 32'd0) ? 2 : 34;
      start_op(a, b, s);
      expect_done("random", lat, model(a, b, s), 1'b1);
      finish_op("random");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle sequencer for 32-bit integer division (DIV/DIVU) behind the execute stage. It latches operands on a start request and runs a 32-step radix-2 restoring divide. It returns `{remainder, quotient}` in HI/LO order with a ready flag. The execute stage holds `start_i` high and raises its stall request until `ready_o` is seen, mirroring the existing MADD/MSUB multi-cycle stall scheme.

## Interface
Parameters:
- `DATA_W`, 32: operand width. Result is `2*DATA_W`. The iteration count equals `DATA_W`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with the operands.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request. Held high by the execute stage until `ready_o` has been taken.
- `annul_i`  in  1  cancel (flush/exception). Aborts any operation not yet in END.
- `result_o`  out  64  `{remainder[63:32], quotient[31:0]}`. Registered.
- `ready_o`  out  1  result valid. Registered.

## Operation
- State machine has four states: FREE, BYZERO, ON, END.
- Internal registers: 65-bit `dividend`, 32-bit `divisor`, 6-bit `cnt`, plus latched copies of the operand signs and `signed_div_i`.
- **FREE**
  - `start_i=1` and `annul_i=0`, divisor 0: go to BYZERO.
  - `start_i=1` and `annul_i=0`, divisor nonzero: go to ON with `cnt=0`, `dividend={32'b0, |op1|, 1'b0}`, `divisor=|op2|`.
  - `|x|` is the two's-complement negation only when signed and `x[31]=1`; otherwise it is the raw value.
  - Any other inputs: stay in FREE.
- **BYZERO**: set `dividend=0` and go to END. The result is all zeros, and no trap is raised.
- **ON**, each edge:
  - `annul_i=1`: go to FREE and clear `cnt`. Outputs are unchanged.
  - `cnt<32`: compute `diff = dividend[63:32] - divisor` in 33 bits.
    - `diff` negative: `dividend = {dividend[63:0], 1'b0}`.
    - Otherwise: `dividend = {diff[31:0], dividend[31:0], 1'b1}`.
    - Then `cnt` increments.
  - `cnt==32`: apply sign correction and go to END with `cnt=0`.
    - When signed and the operand signs differ, negate the quotient `dividend[31:0]`.
    - When signed and the dividend was negative, negate the remainder `dividend[64:33]`.
- **END**, each edge:
  - Drive `result_o={dividend[64:33], dividend[31:0]}` and `ready_o=1`.
  - `start_i=0` instead: go to FREE with `ready_o=0` and `result_o=0`.
  - `annul_i` is ignored in END.
- Operands are latched only in FREE. Changes to `opdata*_i` or `signed_div_i` during ON/END have no effect.
- Signed overflow: `0x80000000 / 0xFFFFFFFF` gives quotient 0x80000000 and remainder 0, with no special casing.

## Timing
- Reset (`rst=0`, asynchronous) forces state FREE, `cnt=0`, `dividend=0`, `divisor=0`, `result_o=0`, `ready_o=0`.
  - Reset takes effect immediately, including mid-operation.
  - After deassertion the block accepts a start on the first edge.
- Let E0 be the edge at which FREE sees `start_i=1`.
- Nonzero divisor:
  - E1–E32 perform the 32 iterations.
  - E33 applies sign correction and enters END.
  - E34 sets `ready_o=1` with a valid `result_o`.
- Zero divisor: E1 enters END and E2 sets `ready_o=1` with `result_o=0`.
- `ready_o` and `result_o` hold while `start_i` stays high.
- At the first edge in END with `start_i=0`, both clear. The block returns to FREE and can accept a new start on the following edge.
- `start_i` and `annul_i` together in FREE: the request is not accepted.
- `annul_i` in ON at any `cnt`: FREE at the next edge. `ready_o` never pulses.

## Test plan
- Unsigned: `signed_div_i=0`, 100 / 7, start held.
  - Required: `ready_o` rises at E34 with `result_o={32'd2, 32'd14}`.
  - After `start_i` drops: `ready_o=0` and `result_o=0` one edge later.
- Signed: −7 / 2 (0xFFFFFFF9 / 0x2).
  - Required: `result_o={0xFFFFFFFF, 0xFFFFFFFD}`, i.e. remainder −1 and quotient −3.
  - Repeat with 7 / −2. Required: `{0x00000001, 0xFFFFFFFD}`.
- Divide by zero: 5 / 0, signed and unsigned.
  - Required: `ready_o=1` at E2 with `result_o=0`.
- Annul: assert `annul_i` for one cycle at `cnt=10`.
  - Required: FREE next edge, `ready_o` stays 0 throughout.
  - Then start 0xFFFFFFFF / 1 unsigned. Required: `{0, 0xFFFFFFFF}` at E34.
- Overflow and operand stability: signed 0x80000000 / 0xFFFFFFFF, with `opdata1_i` toggled during ON.
  - Required: `{0, 0x80000000}`, unaffected by the toggling.
- Reset mid-operation: drive `rst=0` at `cnt=20`.
  - Required: `ready_o=0` and `result_o=0` immediately, without waiting for a clock edge.
  - After release, 9 / 3 returns `{0, 3}` at E34.
